// File: rtl/x_arb_pkg.sv
// Shared types, widths and defaults for the x-vector request arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: address/data widths, addr_t/data_t, default requester count, ceil-log2 helper.
package x_arb_pkg;

  localparam int ADDR_W           = 48;
  localparam int DATA_W           = 64;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_LOG2_NUM_REQ = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Ceiling log2; usable in constant expressions.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/std_fifo.sv
// Generic synchronous FIFO; LATENCY 0 is first-word fall-through (head visible while !empty).
// Latency: push at edge t is readable after edge t; LATENCY>0 adds one register stage on dout.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, empty, full, count (occupancy).
module std_fifo
  import x_arb_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  input  logic                        pop,
  output logic [WIDTH-1:0]            dout,
  output logic                        empty,
  output logic                        full,
  output logic [clog2_int(DEPTH):0]   count
);

  localparam int AW = clog2_int(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push on a full FIFO is still taken.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  generate
    if (LATENCY == 0) begin : g_fwft
      assign dout = mem[rd_ptr[AW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        dout_q <= mem[rd_ptr[AW-1:0]];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: rtl/x_vector_req_arbiter.sv
// Shares one memory request port among NUM_REQ x-vector caches; routes tagged responses back.
// Latency: push at t -> mem_req at t+2; mem_rsp_push at t -> rsp_push at t+1.
// Backpressure: mem_stall holds all FIFOs; pushes into a full FIFO drop and set req_overflow.
// Ports: clk, rst (sync, active-high); req_push/req_addr in, req_almost_full/req_overflow out;
//        mem_req/mem_req_addr/mem_req_tag out, mem_stall in; mem_rsp_push/tag/q in; rsp_push/rsp_q out.
// Optional X_ARB_STATS_EN: adds stat_sel/stat_clr inputs and stat_q (per-requester grant counts).
module x_vector_req_arbiter
  import x_arb_pkg::*;
#(
  parameter int NUM_REQ           = DEF_NUM_REQ,
  parameter int LOG2_NUM_REQ      = DEF_LOG2_NUM_REQ,
  parameter int REQ_FIFO_DEPTH    = 16,
  parameter int ALMOST_FULL_COUNT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef X_ARB_STATS_EN
  input  logic [LOG2_NUM_REQ-1:0]   stat_sel,
  input  logic                      stat_clr,
  output logic [31:0]               stat_q,
`endif
  input  logic [NUM_REQ-1:0]        req_push,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_almost_full,
  output logic [NUM_REQ-1:0]        req_overflow,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [LOG2_NUM_REQ-1:0]   mem_req_tag,
  input  logic                      mem_stall,
  input  logic                      mem_rsp_push,
  input  logic [LOG2_NUM_REQ-1:0]   mem_rsp_tag,
  input  logic [DATA_W-1:0]         mem_rsp_q,
  output logic [NUM_REQ-1:0]        rsp_push,
  output logic [DATA_W-1:0]         rsp_q
);

  localparam int CNT_W = clog2_int(REQ_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(REQ_FIFO_DEPTH - ALMOST_FULL_COUNT);

  logic [NUM_REQ-1:0]      fifo_empty;
  logic [NUM_REQ-1:0]      fifo_full;
  logic [NUM_REQ-1:0]      fifo_pop;
  addr_t                   fifo_head  [NUM_REQ];
  logic [CNT_W-1:0]        fifo_count [NUM_REQ];
  logic [LOG2_NUM_REQ-1:0] last_grant;
  logic [LOG2_NUM_REQ-1:0] grant_idx;
  logic [LOG2_NUM_REQ-1:0] cand;
  logic                    grant_vld;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      std_fifo #(
        .WIDTH  (ADDR_W),
        .DEPTH  (REQ_FIFO_DEPTH),
        .LATENCY(0)
      ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (req_push[i]),
        .din  (req_addr[ADDR_W*i +: ADDR_W]),
        .pop  (fifo_pop[i]),
        .dout (fifo_head[i]),
        .empty(fifo_empty[i]),
        .full (fifo_full[i]),
        .count(fifo_count[i])
      );
      assign fifo_pop[i] = grant_vld && (grant_idx == LOG2_NUM_REQ'(i));
    end
  endgenerate

  // Round-robin pick: scan offsets from farthest to nearest so the nearest
  // non-empty requester after last_grant wins. Offset NUM_REQ truncates to 0,
  // giving last_grant itself the lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = last_grant + LOG2_NUM_REQ'(off);
      if (!fifo_empty[cand]) begin
        grant_vld = !mem_stall;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= LOG2_NUM_REQ'(NUM_REQ - 1);
      mem_req      <= 1'b0;
      mem_req_addr <= '0;
      mem_req_tag  <= '0;
    end else begin
      mem_req <= grant_vld;
      if (grant_vld) begin
        last_grant   <= grant_idx;
        mem_req_addr <= fifo_head[grant_idx];
        mem_req_tag  <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_almost_full <= '0;
      req_overflow    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_almost_full[i] <= (fifo_count[i] >= AF_LEVEL);
        req_overflow[i]    <= req_overflow[i] | (req_push[i] & fifo_full[i] & ~fifo_pop[i]);
      end
    end
  end

  // Responses pass straight through one register stage; no buffering, no backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_push <= '0;
      rsp_q    <= '0;
    end else begin
      rsp_push <= '0;
      if (mem_rsp_push) begin
        rsp_push[mem_rsp_tag] <= 1'b1;
        rsp_q                 <= mem_rsp_q;
      end
    end
  end

`ifdef X_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQ];

  // Clear takes priority over a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fifo_pop[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= grant_cnt[stat_sel];
  end
`endif

endmodule

// File: doc/x_vector_req_arbiter.md
# x_vector_req_arbiter

Shares one memory request/response port among NUM_REQ x-vector cache instances (one per PE lane). Each requester's request pulses are buffered in a small per-requester FIFO. A round-robin arbiter issues them to memory with a requester tag. Tagged responses are routed back to the originating requester's response push.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..16)
- LOG2_NUM_REQ, 2, tag width; equals log2(NUM_REQ)
- REQ_FIFO_DEPTH, 16, per-requester request FIFO depth (power of two)
- ALMOST_FULL_COUNT, 4, headroom for the almost_full flag

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_push  in  NUM_REQ  per-requester request strobe
- req_addr  in  NUM_REQ*48  request addresses; requester i uses bits [48*i+47:48*i]
- req_almost_full  out  NUM_REQ  occupancy of FIFO i ≥ REQ_FIFO_DEPTH − ALMOST_FULL_COUNT
- req_overflow  out  NUM_REQ  sticky: push into a full FIFO i
- mem_req  out  1  memory request valid
- mem_req_addr  out  48  memory request address
- mem_req_tag  out  LOG2_NUM_REQ  requester id of the issued request
- mem_stall  in  1  memory cannot accept a request this cycle
- mem_rsp_push  in  1  memory response valid
- mem_rsp_tag  in  LOG2_NUM_REQ  requester id of the response
- mem_rsp_q  in  64  response data
- rsp_push  out  NUM_REQ  response strobe to requester i
- rsp_q  out  64  response data, shared by all requesters

## Operation
- Request capture: req_push[i] writes req_addr slice i into FIFO i in the same cycle. If FIFO i is full, the entry is dropped and req_overflow[i] sets and stays set until rst. A push and a pop on a full FIFO in the same cycle is accepted, not dropped.
- Arbitration: in each cycle with mem_stall low, the arbiter picks the first non-empty FIFO searching from (last_grant+1) mod NUM_REQ upward with wrap-around. It then pops that FIFO and updates last_grant. last_grant resets to NUM_REQ−1, so requester 0 wins first.
- When mem_stall is high, nothing is popped and last_grant holds.
- Issue: the popped address and the grant index are registered into mem_req_addr and mem_req_tag, with mem_req=1 for exactly one cycle per grant.
- Response routing: mem_rsp_push with mem_rsp_tag=k registers rsp_push[k]=1 and rsp_q=mem_rsp_q. All other bits of rsp_push are 0.
- Response ordering per requester is preserved as delivered by memory. The arbiter adds no reordering and no response buffering.
- The arbiter applies no response backpressure; requesters throttle via their own in-flight accounting.
- Mid-operation rst: all FIFOs are flushed, in-flight tags are forgotten, and outputs return to reset values next cycle. Responses arriving after rst are still routed by tag.

## Timing
- Reset values: mem_req=0, mem_req_addr=0, mem_req_tag=0, rsp_push=0, rsp_q=0, req_almost_full=0, req_overflow=0.
- The FIFO is first-word fall-through. A push at cycle t is eligible for grant at t+1 and appears on mem_req at t+2, the minimum latency.
- Throughput is one request per cycle while mem_stall is low.
- mem_stall is sampled in the grant cycle. mem_stall high at cycle t means mem_req=0 at t+1.
- Response latency is 1 cycle: mem_rsp_push at t gives rsp_push at t+1.
- req_almost_full is registered and lags occupancy by 1 cycle.

## Configuration
- X_ARB_STATS_EN defined:
  - Adds inputs stat_sel (LOG2_NUM_REQ) and stat_clr (1), and output stat_q (32).
  - Each requester has a 32-bit grant counter that wraps at 2^32 and is cleared by rst or stat_clr.
  - stat_q is registered and shows counter[stat_sel] 1 cycle after stat_sel.
  - stat_clr and a grant in the same cycle give a result of 0.
- X_ARB_STATS_EN undefined: these ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- Shared package x_arb_pkg holds:
  - address width 48 and data width 64;
  - the log2 function;
  - the default NUM_REQ and LOG2_NUM_REQ.
- Sub-module: std_fifo, one instance per requester (WIDTH 48, DEPTH REQ_FIFO_DEPTH, LATENCY 0), created with a generate loop.
- The round-robin picker stays inline.

## Test plan
- Single request: req_push[2] with addr 0x1000 at cycle 5 → mem_req at cycle 7 with addr 0x1000 and tag 2.
- Fairness: all four requesters push in the same cycle → grants in order 0, 1, 2, 3 on consecutive cycles. Then with only requesters 1 and 3 pushing continuously → grants alternate 1, 3, 1, 3.
- Stall: mem_stall held high for 5 cycles with 3 requests queued → no mem_req during the stall and no loss. The three requests issue on the 3 cycles after the stall drops, in round-robin order.
- Overflow: 17 pushes to requester 0 under mem_stall → req_almost_full[0] set after occupancy reaches 12, req_overflow[0]=1 on the 17th push, and exactly 16 requests issue after the stall is released.
- Response routing: mem_rsp_push with tag 3 and data 0xDEADBEEF → rsp_push=4'b1000 and rsp_q=0xDEADBEEF the next cycle. Back-to-back responses with tags 0 then 1 → rsp_push bits in consecutive cycles.
- Reset mid-stream: rst with 5 queued requests → all outputs 0 next cycle, no further mem_req, and requester 0 wins the first grant after reset.
